// File: rtl/alu_arbiter.sv
// alu_arbiter
// Shares one registered ALU between two requesters and returns each result on
// a single response channel. Only one operation is ever outstanding.
//
// Ports
//   clk, reset                      clock (rising edge), async active-high reset
//   reqN_valid / reqN_ready         per-requester handshake (N = 0, 1)
//   reqN_op, reqN_rs1, reqN_rs2,
//   reqN_shamt                      operation code and operands
//   resp_valid / resp_ready         response handshake
//   resp_id, resp_data, resp_err    owner index, result, illegal-op flag
//   alu_rs1, alu_rs2, alu_shamt     registered operands to the ALU
//   alu_is_add .. alu_is_sra        one-hot op flags to the ALU
//   alu_valid / alu_ready, alu_out  ALU handshake and result
module alu_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [3:0]  req0_op,
  input  logic [31:0] req0_rs1,
  input  logic [31:0] req0_rs2,
  input  logic [4:0]  req0_shamt,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [3:0]  req1_op,
  input  logic [31:0] req1_rs1,
  input  logic [31:0] req1_rs2,
  input  logic [4:0]  req1_shamt,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_id,
  output logic [31:0] resp_data,
  output logic        resp_err,
  output logic [31:0] alu_rs1,
  output logic [31:0] alu_rs2,
  output logic [4:0]  alu_shamt,
  output logic        alu_is_add,
  output logic        alu_is_sub,
  output logic        alu_is_xor,
  output logic        alu_is_or,
  output logic        alu_is_and,
  output logic        alu_is_sll,
  output logic        alu_is_slt,
  output logic        alu_is_sltu,
  output logic        alu_is_srl,
  output logic        alu_is_sra,
  output logic        alu_valid,
  input  logic        alu_ready,
  input  logic [31:0] alu_out
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  localparam int NUM_OPS = 10;

  logic [1:0]         state_reg;
  logic               last_reg;      // requester served most recently
  logic [NUM_OPS-1:0] flags_reg;
  logic [31:0]        rs1_reg;
  logic [31:0]        rs2_reg;
  logic [4:0]         shamt_reg;
  logic               resp_id_reg;
  logic [31:0]        resp_data_reg;
  logic               resp_err_reg;

  logic               grant;
  logic               idle_open;
  logic               accept;
  logic [3:0]         sel_op;
  logic [31:0]        sel_rs1;
  logic [31:0]        sel_rs2;
  logic [4:0]         sel_shamt;
  logic               sel_legal;
  logic [NUM_OPS-1:0] op_onehot;

  // Round-robin: a lone requester wins; on a tie the one not served last wins.
  always_comb begin
    if (req0_valid && !req1_valid) begin
      grant = 1'b0;
    end else if (req1_valid && !req0_valid) begin
      grant = 1'b1;
    end else begin
      grant = ~last_reg;
    end
  end

  // The alu_ready==0 gate keeps us from issuing while the ALU still shows
  // the ready of the previous transaction (it drops one cycle after valid).
  assign idle_open  = (state_reg == IDLE) && !alu_ready;
  assign req0_ready = idle_open && !grant;
  assign req1_ready = idle_open && grant;
  assign accept     = (req0_ready && req0_valid) || (req1_ready && req1_valid);

  assign sel_op    = grant ? req1_op    : req0_op;
  assign sel_rs1   = grant ? req1_rs1   : req0_rs1;
  assign sel_rs2   = grant ? req1_rs2   : req0_rs2;
  assign sel_shamt = grant ? req1_shamt : req0_shamt;
  assign sel_legal = (sel_op < 4'(NUM_OPS));

  // Op code to one-hot flag decode; codes 10-15 decode to all zeros.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_OPS; gi++) begin : g_dec
      assign op_onehot[gi] = (sel_op == 4'(gi));
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      last_reg      <= 1'b1;  // makes req0 win the first tie
      flags_reg     <= '0;
      rs1_reg       <= '0;
      rs2_reg       <= '0;
      shamt_reg     <= '0;
      resp_id_reg   <= 1'b0;
      resp_data_reg <= '0;
      resp_err_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            last_reg    <= grant;
            resp_id_reg <= grant;
            if (sel_legal) begin
              flags_reg    <= op_onehot;
              rs1_reg      <= sel_rs1;
              rs2_reg      <= sel_rs2;
              shamt_reg    <= sel_shamt;
              resp_err_reg <= 1'b0;
              state_reg    <= ISSUE;
            end else begin
              // Illegal op: skip the ALU and answer straight away.
              resp_err_reg  <= 1'b1;
              resp_data_reg <= '0;
              state_reg     <= RESP;
            end
          end
        end
        ISSUE: begin
          state_reg <= WAIT;
        end
        WAIT: begin
          if (alu_ready) begin
            resp_data_reg <= alu_out;
            flags_reg     <= '0;
            state_reg     <= RESP;
          end
        end
        RESP: begin
          if (resp_ready) begin
            state_reg <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign alu_valid  = (state_reg == ISSUE) || (state_reg == WAIT);
  assign resp_valid = (state_reg == RESP);
  assign resp_id    = resp_id_reg;
  assign resp_data  = resp_data_reg;
  assign resp_err   = resp_err_reg;

  assign alu_rs1   = rs1_reg;
  assign alu_rs2   = rs2_reg;
  assign alu_shamt = shamt_reg;

  assign alu_is_add  = flags_reg[0];
  assign alu_is_sub  = flags_reg[1];
  assign alu_is_xor  = flags_reg[2];
  assign alu_is_or   = flags_reg[3];
  assign alu_is_and  = flags_reg[4];
  assign alu_is_sll  = flags_reg[5];
  assign alu_is_slt  = flags_reg[6];
  assign alu_is_sltu = flags_reg[7];
  assign alu_is_srl  = flags_reg[8];
  assign alu_is_sra  = flags_reg[9];

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed testbench for alu_arbiter with a small registered ALU model.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req0_ready;
  logic [3:0]  req0_op;
  logic [31:0] req0_rs1, req0_rs2;
  logic [4:0]  req0_shamt;
  logic        req1_valid, req1_ready;
  logic [3:0]  req1_op;
  logic [31:0] req1_rs1, req1_rs2;
  logic [4:0]  req1_shamt;
  logic        resp_valid, resp_ready, resp_id, resp_err;
  logic [31:0] resp_data;
  logic [31:0] alu_rs1, alu_rs2;
  logic [4:0]  alu_shamt;
  logic        alu_is_add, alu_is_sub, alu_is_xor, alu_is_or, alu_is_and;
  logic        alu_is_sll, alu_is_slt, alu_is_sltu, alu_is_srl, alu_is_sra;
  logic        alu_valid, alu_ready;
  logic [31:0] alu_out;
  logic [9:0]  flags;

  // ALU model: ready follows valid by one cycle; result registered.
  logic        alu_ready_m = 1'b0;
  logic [31:0] alu_out_m   = '0;
  logic        alu_stall   = 1'b0;
  logic        force_ready = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  assign flags = {alu_is_sra, alu_is_srl, alu_is_sltu, alu_is_slt, alu_is_sll,
                  alu_is_and, alu_is_or, alu_is_xor, alu_is_sub, alu_is_add};
  assign alu_ready = (alu_ready_m && !alu_stall) || force_ready;
  assign alu_out   = alu_out_m;

  function automatic logic [31:0] alu_f();
    logic [31:0] r;
    r = '0;
    if (alu_is_add)  r = alu_rs1 + alu_rs2;
    if (alu_is_sub)  r = alu_rs1 - alu_rs2;
    if (alu_is_xor)  r = alu_rs1 ^ alu_rs2;
    if (alu_is_or)   r = alu_rs1 | alu_rs2;
    if (alu_is_and)  r = alu_rs1 & alu_rs2;
    if (alu_is_sll)  r = alu_rs1 << alu_shamt;
    if (alu_is_slt)  r = {31'd0, $signed(alu_rs1) < $signed(alu_rs2)};
    if (alu_is_sltu) r = {31'd0, alu_rs1 < alu_rs2};
    if (alu_is_srl)  r = alu_rs1 >> alu_shamt;
    if (alu_is_sra)  r = $unsigned($signed(alu_rs1) >>> alu_shamt);
    return r;
  endfunction

  always @(posedge clk) begin
    alu_ready_m <= alu_valid;
    alu_out_m   <= alu_f();
  end

  alu_arbiter dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_rs1(req0_rs1), .req0_rs2(req0_rs2), .req0_shamt(req0_shamt),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_rs1(req1_rs1), .req1_rs2(req1_rs2), .req1_shamt(req1_shamt),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_data(resp_data), .resp_err(resp_err),
    .alu_rs1(alu_rs1), .alu_rs2(alu_rs2), .alu_shamt(alu_shamt),
    .alu_is_add(alu_is_add), .alu_is_sub(alu_is_sub), .alu_is_xor(alu_is_xor),
    .alu_is_or(alu_is_or), .alu_is_and(alu_is_and), .alu_is_sll(alu_is_sll),
    .alu_is_slt(alu_is_slt), .alu_is_sltu(alu_is_sltu), .alu_is_srl(alu_is_srl),
    .alu_is_sra(alu_is_sra), .alu_valid(alu_valid), .alu_ready(alu_ready),
    .alu_out(alu_out)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic ready_of(input int id);
    return (id == 0) ? req0_ready : req1_ready;
  endfunction

  task automatic set_req(input int id, input logic v, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh);
    if (id == 0) begin
      req0_valid = v; req0_op = op; req0_rs1 = a; req0_rs2 = b; req0_shamt = sh;
    end else begin
      req1_valid = v; req1_op = op; req1_rs1 = a; req1_rs2 = b; req1_shamt = sh;
    end
  endtask

  task automatic set_valid(input int id, input logic v);
    if (id == 0) req0_valid = v;
    else         req1_valid = v;
  endtask

  // One complete transaction from a single requester with resp_ready high.
  task automatic run_op(input string tag, input int id, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh,
                        input logic [31:0] exp_data, input logic exp_err);
    int  n;
    bit  seen_valid;
    logic idb;
    idb = (id == 1);
    set_req(id, 1'b1, op, a, b, sh);
    n = 0;
    while (!ready_of(id) && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_accept"}, 64'(ready_of(id)), 64'd1);
    tick();
    set_valid(id, 1'b0);
    n = 1;
    seen_valid = 1'b0;
    while (!resp_valid && n < 20) begin
      if (n == 1 && alu_valid) begin
        check({tag, "_flags"}, 64'(flags), 64'(10'(1) << op));
        check({tag, "_opnd"}, {alu_rs1, alu_rs2}, {a, b});
        check({tag, "_shamt"}, 64'(alu_shamt), 64'(sh));
      end
      seen_valid |= alu_valid;
      tick();
      n++;
    end
    seen_valid |= alu_valid;
    check({tag, "_latency"}, 64'(n), exp_err ? 64'd1 : 64'd3);
    check({tag, "_aluvalid"}, 64'(seen_valid), 64'(!exp_err));
    check({tag, "_resp"}, {30'd0, resp_id, resp_err, resp_data}, {30'd0, idb, exp_err, exp_data});
    $display("txn %s id=%0d op=%0d data=0x%08h err=%0d", tag, id, op, resp_data, resp_err);
    tick();
  endtask

  initial begin
    int n;
    reset = 1'b1;
    resp_ready = 1'b1;
    set_req(0, 1'b0, 4'd0, 32'd0, 32'd0, 5'd0);
    set_req(1, 1'b0, 4'd0, 32'd0, 32'd0, 5'd0);
    tick();
    tick();
    check("rst_ctrl", {59'd0, alu_valid, resp_valid, resp_id, resp_err, 1'b0}, 64'd0);
    check("rst_flags_data", {22'd0, flags, resp_data}, 64'd0);
    check("rst_opnd", {alu_rs1, alu_rs2}, 64'd0);
    reset = 1'b0;
    tick();

    // Directed op vectors with hand-computed results.
    run_op("add",   0, 4'd0,  32'd5,        32'd7,        5'd3, 32'd12,        1'b0);
    run_op("sub",   1, 4'd1,  32'd10,       32'd3,        5'd0, 32'd7,         1'b0);
    run_op("xor",   0, 4'd2,  32'h0000F0F0, 32'h0000FF00, 5'd0, 32'h00000FF0,  1'b0);
    run_op("or",    1, 4'd3,  32'h00000F00, 32'h000000F0, 5'd9, 32'h00000FF0,  1'b0);
    run_op("and",   0, 4'd4,  32'h0000FF0F, 32'h00000FF0, 5'd0, 32'h00000F00,  1'b0);
    run_op("sll",   1, 4'd5,  32'd1,        32'd0,        5'd4, 32'd16,        1'b0);
    run_op("slt",   0, 4'd6,  32'hFFFFFFFF, 32'd1,        5'd0, 32'd1,         1'b0);
    run_op("sltu",  1, 4'd7,  32'hFFFFFFFF, 32'd1,        5'd0, 32'd0,         1'b0);
    run_op("srl",   0, 4'd8,  32'h80000000, 32'd0,        5'd4, 32'h08000000,  1'b0);
    run_op("sra",   1, 4'd9,  32'h80000000, 32'd0,        5'd4, 32'hF8000000,  1'b0);
    run_op("ill12", 1, 4'd12, 32'd55,       32'd66,       5'd1, 32'd0,         1'b1);
    run_op("ill10", 0, 4'd10, 32'd55,       32'd66,       5'd1, 32'd0,         1'b1);
    run_op("after_ill", 0, 4'd0, 32'd100,   32'd23,       5'd0, 32'd123,       1'b0);

    // Backpressure: hold the response for 4 cycles.
    resp_ready = 1'b0;
    set_req(0, 1'b1, 4'd0, 32'd1, 32'd2, 5'd0);
    n = 0;
    while (!req0_ready && n < 20) begin tick(); n++; end
    tick();
    set_valid(0, 1'b0);
    set_req(1, 1'b1, 4'd0, 32'd0, 32'd0, 5'd0);
    n = 0;
    while (!resp_valid && n < 20) begin tick(); n++; end
    for (int i = 0; i < 4; i++) begin
      check("bp_hold", {27'd0, resp_valid, resp_id, resp_err, req0_ready, req1_ready, resp_data},
            {27'd0, 5'b10000, 32'd3});
      tick();
    end
    set_valid(1, 1'b0);
    check("bp_still", 64'(resp_valid), 64'd1);
    resp_ready = 1'b1;
    tick();
    check("bp_release", 64'(resp_valid), 64'd0);

    // Reset while the ALU is stalled in WAIT.
    alu_stall = 1'b1;
    set_req(0, 1'b1, 4'd0, 32'd3, 32'd4, 5'd2);
    n = 0;
    while (!req0_ready && n < 20) begin tick(); n++; end
    tick();
    set_valid(0, 1'b0);
    tick();
    tick();
    check("wait_pre", {62'd0, alu_valid, resp_valid}, 64'b10);
    #2;
    reset = 1'b1;
    #1;
    check("wrst_ctrl", {59'd0, alu_valid, resp_valid, resp_id, resp_err, 1'b0}, 64'd0);
    check("wrst_flags", {27'd0, flags, alu_shamt, 22'd0}, 64'd0);
    check("wrst_opnd", {alu_rs1, alu_rs2}, 64'd0);
    alu_stall = 1'b0;
    force_ready = 1'b1;
    tick();
    reset = 1'b0;
    set_req(0, 1'b1, 4'd1, 32'd9, 32'd4, 5'd0);
    for (int i = 0; i < 3; i++) begin
      check("wrst_gate", {62'd0, req0_ready, resp_valid}, 64'd0);
      tick();
    end
    force_ready = 1'b0;
    #1;
    run_op("post_rst", 0, 4'd1, 32'd9, 32'd4, 5'd0, 32'd5, 1'b0);

    // Round-robin with both requesters continuously valid from reset.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    set_req(0, 1'b1, 4'd0, 32'd1,  32'd1,  5'd0);
    set_req(1, 1'b1, 4'd0, 32'd10, 32'd10, 5'd0);
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (!req0_ready && !req1_ready && n < 20) begin tick(); n++; end
      check("tie_grant", {62'd0, req0_ready, req1_ready}, (k % 2 == 1) ? 64'b01 : 64'b10);
      tick();
      n = 0;
      while (!resp_valid && n < 20) begin tick(); n++; end
      check("tie_resp", {31'd0, resp_id, resp_data},
            (k % 2 == 1) ? {31'd0, 1'b1, 32'd20} : {31'd0, 1'b0, 32'd2});
      $display("txn tie id=%0d data=0x%08h", resp_id, resp_data);
      tick();
    end
    set_valid(0, 1'b0);
    set_valid(1, 1'b0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
